atualizador_aste: RTL and testbench
===================================

// Module: atualizador_aste
// PURPOSE
//  Sweeps the asteroid memory once per game tick: reads each record, advances it one cell
//  in its direction and writes it back. Flags any asteroid that reaches the ship cell.
//  Directly upstream of the asteroid RAM: it owns that RAM's we/addr/data port and consumes q.
//  Record format: [9:6] x, [5:2] y, [1:0] dir.
//  dir: 00 = +x, 01 = -x, 10 = +y, 11 = -y.
// PARAMETERS
//  ADDR_W    4   RAM address width; at most 2**ADDR_W records.
//  COORD_W   4   width of each coordinate; record width is 2*COORD_W+2.
//  GRID_MAX  14  largest legal coordinate; the grid is 0..GRID_MAX on both axes.
//  CENTRO_X  7   ship x position.
//  CENTRO_Y  7   ship y position.
// PORTS
//  clk       in   1          clock; everything is on its rising edge.
//  reset     in   1          synchronous, active-high reset.
//  iniciar   in   1          sweep request; sampled only in IDLE.
//  num_aste  in   ADDR_W+1   number of live records, 0..2**ADDR_W; sampled with iniciar.
//  mem_q     in   2*COORD_W+2  RAM read data; valid one cycle after mem_addr is driven.
//  mem_addr  out  ADDR_W     RAM address.
//  mem_we    out  1          RAM write enable.
//  mem_data  out  2*COORD_W+2  RAM write data.
//  ocupado   out  1          high from the cycle after iniciar is accepted until DONE.
//  pronto    out  1          one-cycle pulse: sweep complete.
//  colisao   out  1          sticky: some asteroid landed on (CENTRO_X,CENTRO_Y) this sweep.
// BEHAVIOUR
//  Reset: state IDLE; mem_we=0, mem_addr=0, mem_data=0, ocupado=0, pronto=0, colisao=0, index=0.
//  States:
//   IDLE  - iniciar=1 latches num_aste into n, clears colisao, index=0.
//           Next state is LE; if n==0 it is DONE instead.
//   LE    - mem_addr=index, mem_we=0. Next state is CALC.
//   CALC  - mem_q holds record[index]. Drive mem_addr=index, mem_we=1, mem_data=moved record.
//           If index==n-1 the next state is DONE; otherwise index+1 and back to LE.
//   DONE  - pronto=1, mem_we=0. Next state is IDLE.
//  Outputs are registered or state-decoded. mem_we is high only in CALC, for exactly one cycle per record.
//  Move rule: only the coordinate named by dir changes, by +1 or -1.
//   - Saturation: +1 at GRID_MAX or -1 at 0 leaves the coordinate unchanged. There is no wrap.
//   - dir bits are always written back unchanged.
//  Collision:
//   - In CALC, if the moved (x,y) equals (CENTRO_X,CENTRO_Y), colisao is set on the next edge.
//   - It stays high through DONE and IDLE and is cleared only by the next accepted iniciar or by reset.
//  Timing: iniciar is accepted at edge t.
//   - LE runs in cycle t+1.
//   - Each record takes 2 cycles.
//   - pronto is high in cycle t+1+2n; n=0 gives pronto in cycle t+1.
//  iniciar while ocupado: ignored, with no queueing. num_aste changes mid-sweep are ignored.
//  num_aste > 2**ADDR_W: clamped to 2**ADDR_W.
//  Reset mid-sweep: the next cycle is IDLE with mem_we=0. Any record not yet written keeps its old value.
//  Read/write same address: a write happens only in CALC, after its read has completed, so there is no hazard.
// TESTING
//  T1 record 0=(0,7,00), n=1, iniciar -> one write addr0 data (1,7,00); pronto at cycle t+3; colisao=0.
//  T2 records (7,14,11),(14,7,01),(7,0,10) -> written as (7,13,11),(13,7,01),(7,1,10); pronto at t+7.
//  T3 record (14,3,00) and (2,0,11) -> saturate: written back unchanged; (0,5,01) -> unchanged.
//  T4 record (6,7,00) -> written as (7,7,00); colisao=1 after CALC, still 1 after pronto.
//     Next iniciar clears it.
//  T5 n=0 -> pronto at t+1, mem_we never asserted. iniciar pulsed during sweep -> no second sweep.
//  T6 reset asserted in the 2nd CALC of a 4-record sweep -> IDLE next cycle, all outputs 0.
//     Records 2..3 unchanged; a fresh sweep then completes normally.

Source files
------------

// File: rtl/atualizador_aste.sv
// Asteroid sweep engine: once per tick, reads every live record from the asteroid RAM,
// moves it one cell along its direction (saturating at the grid edges) and writes it back.
module atualizador_aste #(
  parameter int ADDR_W   = 4,
  parameter int COORD_W  = 4,
  parameter int GRID_MAX = 14,
  parameter int CENTRO_X = 7,
  parameter int CENTRO_Y = 7
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic                   iniciar_i,
  input  logic [ADDR_W:0]        num_aste_i,
  input  logic [2*COORD_W+1:0]   mem_q_i,
  output logic [ADDR_W-1:0]      mem_addr_o,
  output logic                   mem_we_o,
  output logic [2*COORD_W+1:0]   mem_data_o,
  output logic                   ocupado_o,
  output logic                   pronto_o,
  output logic                   colisao_o
);

  localparam int REC_W = 2*COORD_W + 2;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LE   = 2'd1;
  localparam logic [1:0] S_CALC = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [ADDR_W:0]    N_MAX = (ADDR_W+1)'(2**ADDR_W);
  localparam logic [COORD_W-1:0] GMAX  = COORD_W'(GRID_MAX);
  localparam logic [COORD_W-1:0] CX    = COORD_W'(CENTRO_X);
  localparam logic [COORD_W-1:0] CY    = COORD_W'(CENTRO_Y);

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] index_q, index_d;
  logic [ADDR_W:0]   n_q, n_d;
  logic              colisao_q, colisao_d;

  logic [COORD_W-1:0] x, y, nx, ny;
  logic [1:0]         dir;
  logic [REC_W-1:0]   moved;
  logic               last;
  logic               hit;

  // Move rule: one axis, one step, clamped to the grid; dir is passed through.
  always_comb begin
    x   = mem_q_i[REC_W-1 -: COORD_W];
    y   = mem_q_i[2 +: COORD_W];
    dir = mem_q_i[1:0];
    nx  = x;
    ny  = y;
    case (dir)
      2'b00: if (x != GMAX)     nx = x + 1'b1;
      2'b01: if (x != '0)       nx = x - 1'b1;
      2'b10: if (y != GMAX)     ny = y + 1'b1;
      default: if (y != '0)     ny = y - 1'b1;
    endcase
    moved = {nx, ny, dir};
    hit   = (nx == CX) && (ny == CY);
  end

  assign last = ({1'b0, index_q} == (n_q - 1'b1));

  always_comb begin
    state_d   = state_q;
    index_d   = index_q;
    n_d       = n_q;
    colisao_d = colisao_q;
    case (state_q)
      S_IDLE: if (iniciar_i) begin
        n_d       = (num_aste_i > N_MAX) ? N_MAX : num_aste_i;
        colisao_d = 1'b0;
        index_d   = '0;
        state_d   = (num_aste_i == '0) ? S_DONE : S_LE;
      end
      S_LE: state_d = S_CALC;
      S_CALC: begin
        if (hit) colisao_d = 1'b1;
        if (last) state_d = S_DONE;
        else begin
          index_d = index_q + 1'b1;
          state_d = S_LE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q   <= S_IDLE;
      index_q   <= '0;
      n_q       <= '0;
      colisao_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      index_q   <= index_d;
      n_q       <= n_d;
      colisao_q <= colisao_d;
    end
  end

  // RAM data is only valid in CALC, so the write data is gated to keep idle outputs at zero.
  assign mem_addr_o = index_q;
  assign mem_we_o   = (state_q == S_CALC);
  assign mem_data_o = (state_q == S_CALC) ? moved : '0;
  assign ocupado_o  = (state_q != S_IDLE);
  assign pronto_o   = (state_q == S_DONE);
  assign colisao_o  = colisao_q;

endmodule

// File: tb/tb_atualizador_aste.sv
// Directed bench for atualizador_aste with a behavioural synchronous RAM attached.
module tb_atualizador_aste;

  logic       clk = 1'b0;
  logic       reset;
  logic       iniciar;
  logic [4:0] num_aste;
  logic [9:0] mem_q;
  logic [3:0] mem_addr;
  logic       mem_we;
  logic [9:0] mem_data;
  logic       ocupado, pronto, colisao;

  logic [9:0] ram [16];
  logic       tb_we;
  logic [3:0] tb_addr;
  logic [9:0] tb_data;
  int         wcnt = 0;
  int         checks = 0, failures = 0;

  always #5 clk = ~clk;

  atualizador_aste dut (
    .clk_i(clk), .reset_i(reset), .iniciar_i(iniciar), .num_aste_i(num_aste),
    .mem_q_i(mem_q), .mem_addr_o(mem_addr), .mem_we_o(mem_we), .mem_data_o(mem_data),
    .ocupado_o(ocupado), .pronto_o(pronto), .colisao_o(colisao)
  );

  always @(posedge clk) begin
    if (mem_we) begin
      ram[mem_addr] <= mem_data;
      wcnt <= wcnt + 1;
    end else if (tb_we) ram[tb_addr] <= tb_data;
    mem_q <= ram[mem_addr];
  end

  function automatic logic [9:0] rec(input int x, input int y, input int d);
    rec = {4'(x), 4'(y), 2'(d)};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic load(input int a, input logic [9:0] v);
    tb_we = 1'b1; tb_addr = 4'(a); tb_data = v;
    @(negedge clk);
    tb_we = 1'b0;
  endtask

  // Accept a sweep and return the cycle (relative to the accepting edge) where pronto rises.
  task automatic sweep(input logic [4:0] n, output int lat);
    iniciar = 1'b1; num_aste = n;
    @(negedge clk);
    iniciar = 1'b0;
    lat = 1;
    while (!pronto && lat < 200) begin
      @(negedge clk);
      lat++;
    end
  endtask

  initial begin
    int lat, w0;
    reset = 1'b1; iniciar = 1'b0; num_aste = '0;
    tb_we = 1'b0; tb_addr = '0; tb_data = '0;
    for (int i = 0; i < 16; i++) ram[i] = '0;
    repeat (3) @(negedge clk);
    chk("rst_we", 32'(mem_we), 0);
    chk("rst_addr", 32'(mem_addr), 0);
    chk("rst_data", 32'(mem_data), 0);
    chk("rst_flags", {29'd0, ocupado, pronto, colisao}, 0);
    reset = 1'b0;
    @(negedge clk);

    // T1
    load(0, rec(0, 7, 0));
    w0 = wcnt;
    sweep(5'd1, lat);
    chk("t1_lat", 32'(lat), 3);
    @(negedge clk);
    chk("t1_pulse", {30'd0, pronto, ocupado}, 0);
    chk("t1_rec", 32'(ram[0]), 32'(rec(1, 7, 0)));
    chk("t1_wcnt", 32'(wcnt - w0), 1);
    chk("t1_col", 32'(colisao), 0);

    // T2
    load(0, rec(7, 14, 3)); load(1, rec(14, 7, 1)); load(2, rec(7, 0, 2));
    sweep(5'd3, lat);
    chk("t2_lat", 32'(lat), 7);
    @(negedge clk);
    chk("t2_r0", 32'(ram[0]), 32'(rec(7, 13, 3)));
    chk("t2_r1", 32'(ram[1]), 32'(rec(13, 7, 1)));
    chk("t2_r2", 32'(ram[2]), 32'(rec(7, 1, 2)));

    // T3 saturation
    load(0, rec(14, 3, 0)); load(1, rec(2, 0, 3)); load(2, rec(0, 5, 1));
    sweep(5'd3, lat);
    @(negedge clk);
    chk("t3_r0", 32'(ram[0]), 32'(rec(14, 3, 0)));
    chk("t3_r1", 32'(ram[1]), 32'(rec(2, 0, 3)));
    chk("t3_r2", 32'(ram[2]), 32'(rec(0, 5, 1)));

    // T4 collision, sticky until next accepted iniciar
    load(0, rec(6, 7, 0));
    sweep(5'd1, lat);
    chk("t4_col_pronto", 32'(colisao), 1);
    @(negedge clk);
    chk("t4_col_idle", 32'(colisao), 1);
    chk("t4_r0", 32'(ram[0]), 32'(rec(7, 7, 0)));
    iniciar = 1'b1; num_aste = 5'd1;
    @(negedge clk);
    iniciar = 1'b0;
    chk("t4_col_clr", 32'(colisao), 0);
    chk("t4_ocup", 32'(ocupado), 1);
    repeat (3) @(negedge clk);
    chk("t4_col_after", 32'(colisao), 0);
    chk("t4_r0b", 32'(ram[0]), 32'(rec(8, 7, 0)));

    // T5 n=0, then iniciar/num_aste disturbance during a sweep
    w0 = wcnt;
    sweep(5'd0, lat);
    chk("t5_lat0", 32'(lat), 1);
    @(negedge clk);
    chk("t5_wcnt0", 32'(wcnt - w0), 0);
    load(0, rec(1, 1, 0)); load(1, rec(1, 1, 2));
    w0 = wcnt;
    iniciar = 1'b1; num_aste = 5'd2;
    @(negedge clk);
    iniciar = 1'b0;
    @(negedge clk);
    iniciar = 1'b1; num_aste = 5'd5;
    @(negedge clk);
    iniciar = 1'b0;
    repeat (12) @(negedge clk);
    chk("t5_wcnt", 32'(wcnt - w0), 2);
    chk("t5_idle", 32'(ocupado), 0);
    chk("t5_r0", 32'(ram[0]), 32'(rec(2, 1, 0)));
    chk("t5_r1", 32'(ram[1]), 32'(rec(1, 2, 2)));

    // num_aste above capacity clamps to 16 records
    for (int i = 0; i < 16; i++) load(i, rec(3, 3, 2));
    w0 = wcnt;
    sweep(5'd31, lat);
    chk("clamp_lat", 32'(lat), 33);
    @(negedge clk);
    chk("clamp_wcnt", 32'(wcnt - w0), 16);
    chk("clamp_r15", 32'(ram[15]), 32'(rec(3, 4, 2)));

    // T6 reset in the second CALC of a 4-record sweep
    for (int i = 0; i < 4; i++) load(i, rec(i, 10, 0));
    iniciar = 1'b1; num_aste = 5'd4;
    @(negedge clk);
    iniciar = 1'b0;
    repeat (3) @(negedge clk);
    chk("t6_in_calc", 32'(mem_we), 1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("t6_outs", {18'd0, mem_addr, mem_we, ocupado, pronto, colisao, 6'd0}, 0);
    chk("t6_data", 32'(mem_data), 0);
    chk("t6_r2", 32'(ram[2]), 32'(rec(2, 10, 0)));
    chk("t6_r3", 32'(ram[3]), 32'(rec(3, 10, 0)));
    chk("t6_r0", 32'(ram[0]), 32'(rec(1, 10, 0)));
    for (int i = 0; i < 4; i++) load(i, rec(i, 10, 0));
    sweep(5'd4, lat);
    chk("t6_lat", 32'(lat), 9);
    @(negedge clk);
    chk("t6_f0", 32'(ram[0]), 32'(rec(1, 10, 0)));
    chk("t6_f3", 32'(ram[3]), 32'(rec(4, 10, 0)));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
